// File: rtl/parity_serial_checker.sv
// Receive-side framed serial parity checker: start, DATA_BITS data (LSB first), parity, stop.
// Emits one result pulse per frame plus a saturating error counter for debug.
module parity_serial_checker #(
    parameter int DATA_BITS     = 4,
    parameter bit PARITY_INVERT = 1'b0,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 in_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 out_valid,
    output logic                 par_err,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     err_count,
    output logic                 busy
);

    localparam int CW = (DATA_BITS < 2) ? 1 : $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [DATA_BITS:0]   shift_cat;
    logic                 par_bad;
    logic                 stop_bad;

    // New bits enter at the MSB so the first data bit ends up in bit 0.
    assign shift_cat = {rx, shreg};
    assign par_bad   = (par_bit != ((^shreg) ^ PARITY_INVERT));
    assign stop_bad  = ~rx;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        if (in_valid) begin
            case (state)
                IDLE:    if (!rx) state_nxt = DATA;
                DATA:    if (cnt == LAST) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            if (in_valid) begin
                case (state)
                    IDLE: begin
                        if (!rx) cnt <= '0;
                    end
                    DATA: begin
                        shreg <= shift_cat[DATA_BITS:1];
                        cnt   <= cnt + 1'b1;
                    end
                    PARITY: begin
                        par_bit <= rx;
                    end
                    STOP: begin
                        data_out  <= shreg;
                        par_err   <= par_bad;
                        frame_err <= stop_bad;
                        out_valid <= 1'b1;
                        if ((par_bad || stop_bad) && (err_count != '1))
                            err_count <= err_count + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parity_serial_checker.sv
// Directed bench for parity_serial_checker: default, inverted-parity and 2-bit-counter instances.
module tb_parity_serial_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic in_valid = 1'b0;

    logic [3:0] data0, data1, data2;
    logic       ov0, ov1, ov2;
    logic       pe0, pe1, pe2;
    logic       fe0, fe1, fe2;
    logic [7:0] ec0, ec1;
    logic [1:0] ec2;
    logic       busy0, busy1, busy2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gap_busy_bad = 0;
    logic [5:0] res_q[$];
    int         cyc_q[$];

    parity_serial_checker #(.DATA_BITS(4), .PARITY_INVERT(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .rx(rx), .in_valid(in_valid),
        .data_out(data0), .out_valid(ov0), .par_err(pe0), .frame_err(fe0),
        .err_count(ec0), .busy(busy0));

    parity_serial_checker #(.DATA_BITS(4), .PARITY_INVERT(1'b1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .rx(rx), .in_valid(in_valid),
        .data_out(data1), .out_valid(ov1), .par_err(pe1), .frame_err(fe1),
        .err_count(ec1), .busy(busy1));

    parity_serial_checker #(.DATA_BITS(4), .PARITY_INVERT(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .rx(rx), .in_valid(in_valid),
        .data_out(data2), .out_valid(ov2), .par_err(pe2), .frame_err(fe2),
        .err_count(ec2), .busy(busy2));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ov0) begin
            res_q.push_back({fe0, pe0, data0});
            cyc_q.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        @(negedge clk);
        rx = b;
        in_valid = 1'b1;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            rx = ~b;
            if (!busy0) gap_busy_bad++;
        end
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic s, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < 4; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        send_bit(s, 0);
    endtask

    task automatic expect_frame(input string tag, input logic [3:0] d, input logic pe, input logic fe);
        logic [5:0] r;
        int n;
        n = 0;
        @(negedge clk);
        rx = 1'b1;
        in_valid = 1'b0;
        #1;
        while (res_q.size() == 0 && n < 4) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val({tag, "_ov"}, 32'(res_q.size() != 0), 32'd1);
        if (res_q.size() != 0) begin
            r = res_q.pop_front();
            check_val({tag, "_data"}, 32'(r[3:0]), 32'(d));
            check_val({tag, "_par_err"}, 32'(r[4]), 32'(pe));
            check_val({tag, "_frame_err"}, 32'(r[5]), 32'(fe));
        end
    endtask

    initial begin
        int t0, t1, n0;
        int exp_sat[5] = '{1, 2, 3, 3, 3};

        // reset and idle
        #3;
        check_val("rst_data", 32'(data0), 32'd0);
        check_val("rst_ov", 32'(ov0), 32'd0);
        check_val("rst_busy", 32'(busy0), 32'd0);
        check_val("rst_ec", 32'(ec0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        in_valid = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check_val("idle_busy", 32'(busy0), 32'd0);
        check_val("idle_no_ov", 32'(res_q.size()), 32'd0);
        check_val("idle_flags", 32'({pe0, fe0, data0, ec0}), 32'd0);

        // good frame 4'hD
        send_frame(4'hD, 1'b1, 1'b1, 0);
        expect_frame("good", 4'hD, 1'b0, 1'b0);
        check_val("good_ec", 32'(ec0), 32'd0);
        check_val("good_inv_par_err", 32'(pe1), 32'd1);
        @(negedge clk);
        #1;
        check_val("good_ov_one_cycle", 32'(ov0), 32'd0);

        // parity error frame
        send_frame(4'hD, 1'b0, 1'b1, 0);
        expect_frame("perr", 4'hD, 1'b1, 1'b0);
        check_val("perr_ec", 32'(ec0), 32'd1);
        check_val("perr_inv_par_err", 32'(pe1), 32'd0);
        check_val("perr_inv_data", 32'(data1), 32'hD);

        // framing error then back-to-back good frame
        send_frame(4'h0, 1'b0, 1'b0, 0);
        send_frame(4'hF, 1'b0, 1'b1, 0);
        expect_frame("ferr", 4'h0, 1'b0, 1'b1);
        expect_frame("b2b", 4'hF, 1'b0, 1'b0);
        if (cyc_q.size() >= 4) begin
            t0 = cyc_q[2];
            t1 = cyc_q[3];
            check_val("b2b_spacing", 32'(t1 - t0), 32'd7);
        end else begin
            check_val("b2b_pulse_count", 32'(cyc_q.size()), 32'd4);
        end
        check_val("b2b_ec", 32'(ec0), 32'd2);

        // in_valid gaps
        gap_busy_bad = 0;
        send_frame(4'hD, 1'b1, 1'b1, 3);
        expect_frame("gap", 4'hD, 1'b0, 1'b0);
        check_val("gap_busy_held", 32'(gap_busy_bad), 32'd0);
        check_val("gap_ec", 32'(ec0), 32'd2);

        // reset mid-frame
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_val("mid_busy_before", 32'(busy0), 32'd1);
        rst = 1'b1;
        #1;
        check_val("mid_busy_after_rst", 32'(busy0), 32'd0);
        check_val("mid_ec_cleared", 32'(ec0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n0 = res_q.size();
        repeat (5) @(negedge clk);
        #1;
        check_val("mid_no_ov", 32'(res_q.size()), 32'(n0));
        send_frame(4'hA, 1'b0, 1'b1, 0);
        expect_frame("after_rst", 4'hA, 1'b0, 1'b0);

        // saturation on the 2-bit counter
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_frame(4'hD, 1'b0, 1'b1, 0);
            expect_frame("sat", 4'hD, 1'b1, 1'b0);
            check_val($sformatf("sat_ec_%0d", k), 32'(ec2), 32'(exp_sat[k]));
        end
        check_val("sat_ec_wide", 32'(ec0), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_serial_checker.md
Name: parity_serial_checker

Overview:
- Receive-side counterpart to the team's combinational parity generator.
- Deserialises a framed bit stream: start bit, DATA_BITS data bits LSB first, one parity bit, one stop bit.
- Recomputes parity on the received data and reports data, parity error and framing error.
- Sits at the receive end of the serial link. Produces one result per frame plus a saturating error counter for debug.

Parameters:
DATA_BITS, 4, number of data bits per frame (legal range 1..16)
PARITY_INVERT, 0, expected parity bit = XOR of data bits XOR PARITY_INVERT (0 matches generator p = a^b^c^d)
CNT_W, 8, width of error counter

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous active-high reset
rx  input  1  serial line bit, idle level 1
in_valid  input  1  rx is sampled only on edges where in_valid=1
data_out  output  DATA_BITS  last received data word, bit 0 = first data bit received
out_valid  output  1  one-cycle pulse: frame complete, data_out/par_err/frame_err valid
par_err  output  1  parity mismatch for the frame flagged by out_valid
frame_err  output  1  stop bit was 0 for the frame flagged by out_valid
err_count  output  CNT_W  count of frames with par_err or frame_err, saturating
busy  output  1  1 when state is not IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, bit counter=0, shift register=0.
  - data_out=0, out_valid=0, par_err=0, frame_err=0, err_count=0, busy=0.
  - rst mid-frame discards the partial frame. No out_valid is produced for it.
- Edges with in_valid=0 change nothing except the out_valid deassertion. State, counter and shift register hold.
- States and transitions (evaluated only on edges with in_valid=1):
  - IDLE: rx=0 -> DATA, counter cleared. rx=1 -> stay in IDLE.
  - DATA: rx shifted in LSB first and counter incremented. After the DATA_BITS-th bit -> PARITY.
  - PARITY: rx captured as received parity bit -> STOP.
  - STOP: rx sampled as stop bit -> IDLE. The frame result is registered on this edge.
- Result:
  - On the STOP sampling edge, register:
    - data_out = shift register contents
    - par_err = (received parity != (^data XOR PARITY_INVERT))
    - frame_err = (stop bit == 0)
  - out_valid=1 for exactly the following cycle, then 0.
  - data_out, par_err and frame_err hold until the next frame completes.
- Frames with errors are still delivered: out_valid fires and data_out is updated.
- Latency: out_valid is asserted in the cycle immediately after the edge that samples the stop bit.
- Back-to-back frames: a start bit may be sampled in the same cycle out_valid is high. It is accepted with no dead cycle.
- err_count increments by 1 on the STOP edge if par_err or frame_err is set. It saturates at all-ones.
- busy = (state != IDLE), decoded combinationally from the state register.
- A stop bit of 0 returns to IDLE like any other stop bit. No resynchronisation or break detection.

Test Plan:
- Reset and idle: rst pulse, then rx=1, in_valid=1 for 20 cycles -> all outputs 0, busy=0, no out_valid.
- Good frame (DATA_BITS=4, PARITY_INVERT=0): rx sequence 0,1,0,1,1,1,1 (data 4'b1101, parity 1, stop 1) -> next cycle out_valid=1, data_out=4'hD, par_err=0, frame_err=0, err_count=0.
- Parity error: same frame with parity bit 0 -> data_out=4'hD, par_err=1, frame_err=0, err_count=1. Repeat with PARITY_INVERT=1 and parity 0 -> par_err=0.
- Framing error plus back-to-back frames:
  - Frame 0,0,0,0,0,0,0 (data 0, parity 0, stop 0) -> frame_err=1, par_err=0.
  - Immediately followed by a good frame for data 4'hF (0,1,1,1,1,0,1) -> second out_valid exactly 7 cycles after the first, data_out=4'hF, no errors.
- in_valid gaps: the good frame 4'hD with in_valid=0 inserted for 3 cycles between every bit -> identical result to the ungapped case; busy held high throughout.
- Reset mid-frame and saturation:
  - Assert rst after 3 data bits -> immediate return to IDLE, no out_valid; the next full frame decodes correctly.
  - With CNT_W=2, send 5 parity-error frames -> err_count reads 1,2,3,3,3.
